block_plotter: RTL and testbench

- Consumes the block coordinate and colour produced by the game's load stage: x (8b), y (7b), colour (3b, black = erase), qualified by a one-cycle load-done strobe.
- Rasterises a BLOCK_W x BLOCK_H square, one pixel per clock, onto the 160x120 VGA adapter write port.
- Also serves a full-screen clear command used at game start/reset of play.
- Sits between the load stage and the VGA adapter; the game FSM waits on its done pulse before advancing.

---
 rtl/block_plotter_if.sv | 28 ++
 rtl/block_plotter.sv | 123 ++++++++++++
 tb/tb_block_plotter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/block_plotter_if.sv
// Command/pixel bus between the load stage, the block plotter and the VGA adapter write port.
interface block_plotter_if;
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;

  logic          start;
  logic          clear;
  logic [XW-1:0] x_in;
  logic [YW-1:0] y_in;
  logic [CW-1:0] colour_in;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic          plot;
  logic          busy;
  logic          done;

  modport master (
    output start, clear, x_in, y_in, colour_in,
    input  vga_x, vga_y, vga_colour, plot, busy, done
  );

  modport slave (
    input  start, clear, x_in, y_in, colour_in,
    output vga_x, vga_y, vga_colour, plot, busy, done
  );
endinterface

// File: rtl/block_plotter.sv
// Rasterises a BLOCK_W x BLOCK_H block (or a full-screen clear) onto the VGA
// write port, one candidate pixel per clock, with off-screen pixels clipped.
module block_plotter #(
  parameter int unsigned BLOCK_W  = 4,
  parameter int unsigned BLOCK_H  = 4,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic           clk,
  input  logic           reset,
  block_plotter_if.slave bus
);
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, BLK, CLR, FIN} state_t;

  state_t        state;
  logic [XW-1:0] bx, cx, vga_x;
  logic [YW-1:0] by, cy, vga_y;
  logic [CW-1:0] bc, vga_colour;
  logic          plot, busy, done;

  // One bit wider than the operands so off-screen sums never wrap back on screen.
  logic [XW:0] sum_x_c;
  logic [YW:0] sum_y_c;
  assign sum_x_c = {1'b0, bx} + {1'b0, cx};
  assign sum_y_c = {1'b0, by} + {1'b0, cy};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bx         <= '0;
      by         <= '0;
      bc         <= '0;
      cx         <= '0;
      cy         <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          // busy is still high for the cycle right after FIN; commands are refused then too.
          if (busy) begin
            busy <= 1'b0;
          end else if (bus.clear) begin
            cx    <= '0;
            cy    <= '0;
            busy  <= 1'b1;
            state <= CLR;
          end else if (bus.start) begin
            bx    <= bus.x_in;
            by    <= bus.y_in;
            bc    <= bus.colour_in;
            cx    <= '0;
            cy    <= '0;
            busy  <= 1'b1;
            state <= BLK;
          end
        end

        BLK: begin
          if (sum_x_c < (XW+1)'(SCREEN_W) && sum_y_c < (YW+1)'(SCREEN_H)) begin
            plot       <= 1'b1;
            vga_x      <= sum_x_c[XW-1:0];
            vga_y      <= sum_y_c[YW-1:0];
            vga_colour <= bc;
          end
          if (cx == XW'(BLOCK_W - 1)) begin
            cx <= '0;
            if (cy == YW'(BLOCK_H - 1)) begin
              cy    <= '0;
              state <= FIN;
            end else begin
              cy <= cy + YW'(1);
            end
          end else begin
            cx <= cx + XW'(1);
          end
        end

        CLR: begin
          plot       <= 1'b1;
          vga_x      <= cx;
          vga_y      <= cy;
          vga_colour <= '0;
          if (cx == XW'(SCREEN_W - 1)) begin
            cx <= '0;
            if (cy == YW'(SCREEN_H - 1)) begin
              cy    <= '0;
              state <= FIN;
            end else begin
              cy <= cy + YW'(1);
            end
          end else begin
            cx <= cx + XW'(1);
          end
        end

        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vga_x      = vga_x;
  assign bus.vga_y      = vga_y;
  assign bus.vga_colour = vga_colour;
  assign bus.plot       = plot;
  assign bus.busy       = busy;
  assign bus.done       = done;
endmodule

// File: tb/tb_block_plotter.sv
// Self-checking bench for block_plotter: vector table of block commands plus
// hand-written clear, ignored-start and mid-command reset sequences.
module tb_block_plotter;
  logic clk;
  logic reset;

  block_plotter_if bus();

  block_plotter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         exp_plots;
    int         exp_done;
  } vec_t;

  pix_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Pixel scoreboard: every plotted pixel must be the next expected one.
  always @(negedge clk) begin
    if (!reset && bus.plot === 1'b1) begin
      pix_t got;
      got = '{x: bus.vga_x, y: bus.vga_y, c: bus.vga_colour};
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d expected none",
                 got.x, got.y, got.c);
      end else begin
        pix_t exp;
        exp = sb.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL pixel: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                   got.x, got.y, got.c, exp.x, exp.y, exp.c);
        end
      end
    end
  end

  task automatic push_block(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        int sx;
        int sy;
        sx = int'(x) + i;
        sy = int'(y) + j;
        if (sx < 160 && sy < 120) sb.push_back('{x: 8'(sx), y: 7'(sy), c: c});
      end
    end
  endtask

  task automatic push_clear();
    for (int j = 0; j < 120; j++)
      for (int i = 0; i < 160; i++)
        sb.push_back('{x: 8'(i), y: 7'(j), c: 3'b000});
  endtask

  // Issue one command and follow it to completion with a bounded cycle budget.
  task automatic run_cmd(input string tag, input logic is_clr, input logic [7:0] x,
                         input logic [6:0] y, input logic [2:0] c, input int exp_plots,
                         input int exp_done, input int glitch_at);
    int plots = 0;
    int dones = 0;
    int first = 0;
    if (is_clr) push_clear(); else push_block(x, y, c);
    @(negedge clk);
    bus.clear     = is_clr;
    bus.start     = 1'b1;
    bus.x_in      = x;
    bus.y_in      = y;
    bus.colour_in = c;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    for (int k = 1; k <= exp_done + 4; k++) begin
      @(posedge clk);
      #1;
      if (bus.plot === 1'b1) plots++;
      if (bus.done === 1'b1) begin
        dones++;
        if (first == 0) begin
          first = k;
          check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
        end
      end
      if (first != 0 && k == first + 1) begin
        check({tag, "_busy_after_done"}, 32'(bus.busy), 32'd0);
        break;
      end
      if (glitch_at > 0 && k == glitch_at) begin
        bus.start = 1'b1;
        bus.x_in  = 8'd40;
      end else if (glitch_at > 0 && k == glitch_at + 1) begin
        bus.start = 1'b0;
      end
    end
    check({tag, "_done_cycle"}, 32'(first), 32'(exp_done));
    check({tag, "_plot_count"}, 32'(plots), 32'(exp_plots));
    check({tag, "_done_pulses"}, 32'(dones), 32'd1);
    check({tag, "_pixels_left"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{x: 8'd8,   y: 7'd116, c: 3'b100, exp_plots: 16, exp_done: 17};
    vecs[1] = '{x: 8'd156, y: 7'd0,   c: 3'b000, exp_plots: 16, exp_done: 17};
    vecs[2] = '{x: 8'd158, y: 7'd118, c: 3'b101, exp_plots: 4,  exp_done: 17};
    vecs[3] = '{x: 8'd0,   y: 7'd0,   c: 3'b111, exp_plots: 16, exp_done: 17};
    vecs[4] = '{x: 8'd157, y: 7'd119, c: 3'b011, exp_plots: 3,  exp_done: 17};
    vecs[5] = '{x: 8'd255, y: 7'd127, c: 3'b110, exp_plots: 0,  exp_done: 17};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.clear     = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.colour_in = '0;
    repeat (2) @(negedge clk);
    check("rst_vga_x", 32'(bus.vga_x), 32'd0);
    check("rst_vga_y", 32'(bus.vga_y), 32'd0);
    check("rst_vga_colour", 32'(bus.vga_colour), 32'd0);
    check("rst_plot", 32'(bus.plot), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_cmd($sformatf("vec%0d", v), 1'b0, vecs[v].x, vecs[v].y, vecs[v].c,
              vecs[v].exp_plots, vecs[v].exp_done, 0);
    end

    // clear wins over a simultaneous start; start is never served.
    run_cmd("clear", 1'b1, 8'd8, 7'd8, 3'b111, 19200, 19201, 0);

    // start while busy is ignored; original coordinates used throughout.
    run_cmd("busy_start", 1'b0, 8'd12, 7'd20, 3'b010, 16, 17, 5);

    // Reset in the middle of a block command.
    push_block(8'd20, 7'd30, 3'b001);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.x_in      = 8'd20;
    bus.y_in      = 7'd30;
    bus.colour_in = 3'b001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    check("midrst_vga_x", 32'(bus.vga_x), 32'd0);
    check("midrst_vga_y", 32'(bus.vga_y), 32'd0);
    check("midrst_vga_colour", 32'(bus.vga_colour), 32'd0);
    check("midrst_plot", 32'(bus.plot), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    sb.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("midrst_no_done", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      check("after_rst_idle_done", 32'(bus.done), 32'd0);
    end
    run_cmd("fresh", 1'b0, 8'd50, 7'd60, 3'b110, 16, 17, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
